// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Control sequencer for the RV32I next-PC select mux and PC register. Every cycle it chooses the
// next-PC source and the PC write enable from fetch readiness, the decode hazard stall and the
// execute-stage control-flow resolution. It also raises IF/ID and ID/EX flush pulses after a
// redirect and runs a one-cycle boot step after reset and a sticky halt.
//
// Optional feature: define PC_SEQ_PERF_EN to add the o_redirect_cnt / o_stall_cnt performance
// counters. With the macro undefined those ports and counters do not exist.
//
// Parameters
//   FLUSH_CYCLES    cycles both flushes stay high after a redirect, including the redirect
//                   cycle itself (legal range 1..15)
//
// Ports
//   i_clk           core clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_imem_ready    instruction memory returns data for the current PC this cycle
//   i_stall         load-use / hazard stall from decode: hold the PC
//   i_ex_valid      execute-stage instruction is valid (not a bubble)
//   i_ex_branch     execute instruction is a conditional branch that resolved taken
//   i_ex_jal        execute instruction is JAL
//   i_ex_jalr       execute instruction is JALR
//   i_halt_req      ECALL/EBREAK retired: stop fetching
//   o_pc_sel        next-PC mux select: 00 PC+4, 01 PC+imm, 10 ALU result, 11 ALU&~1 (JALR)
//   o_pc_en         PC register write enable
//   o_imem_req      instruction fetch request
//   o_flush_if_id   squash the IF/ID register
//   o_flush_id_ex   squash the ID/EX register
//   o_halted        core halted
//   o_redirect_cnt  (PC_SEQ_PERF_EN) cycles in which a redirect was applied, wraps mod 2^32
//   o_stall_cnt     (PC_SEQ_PERF_EN) RUN/FLUSH cycles with PC write disabled, wraps mod 2^32
// ---------------------------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_imem_ready,
    input  logic        i_stall,
    input  logic        i_ex_valid,
    input  logic        i_ex_branch,
    input  logic        i_ex_jal,
    input  logic        i_ex_jalr,
    input  logic        i_halt_req,
`ifdef PC_SEQ_PERF_EN
    output logic [31:0] o_redirect_cnt,
    output logic [31:0] o_stall_cnt,
`endif
    output logic [1:0]  o_pc_sel,
    output logic        o_pc_en,
    output logic        o_imem_req,
    output logic        o_flush_if_id,
    output logic        o_flush_id_ex,
    output logic        o_halted
);

    typedef enum logic [1:0] {
        StBoot  = 2'b00,
        StRun   = 2'b01,
        StFlush = 2'b10,
        StHalt  = 2'b11
    } state_e;

    localparam logic [1:0] SelPc4    = 2'b00;
    localparam logic [1:0] SelBranch = 2'b01;
    localparam logic [1:0] SelJal    = 2'b10;
    localparam logic [1:0] SelJalr   = 2'b11;

    // The redirect cycle itself is the first flush cycle, so FLUSH only covers the remainder.
    localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES - 1);

    state_e     r_state;
    state_e     w_state_next;
    logic [3:0] r_flush_cnt;
    logic [3:0] w_flush_cnt_next;

    logic       w_redirect;
    logic [1:0] w_redirect_sel;
    logic       w_fetch_adv;

    assign w_redirect  = i_ex_valid & (i_ex_jalr | i_ex_jal | i_ex_branch);
    assign w_fetch_adv = i_imem_ready & ~i_stall;

    // JALR outranks JAL, which outranks a taken branch.
    always_comb begin
        w_redirect_sel = SelBranch;
        if (i_ex_jalr) begin
            w_redirect_sel = SelJalr;
        end else if (i_ex_jal) begin
            w_redirect_sel = SelJal;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StBoot;
            r_flush_cnt <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_flush_cnt <= w_flush_cnt_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_flush_cnt_next = r_flush_cnt;
        o_pc_sel         = SelPc4;
        o_pc_en          = 1'b0;
        o_imem_req       = 1'b0;
        o_flush_if_id    = 1'b0;
        o_flush_id_ex    = 1'b0;
        o_halted         = 1'b0;

        unique case (r_state)
            StBoot: begin
                w_state_next = StRun;
            end

            StRun: begin
                o_imem_req = 1'b1;
                if (w_redirect) begin
                    // A resolved redirect must land even when fetch is stalled or not ready.
                    o_pc_sel         = w_redirect_sel;
                    o_pc_en          = 1'b1;
                    o_flush_if_id    = 1'b1;
                    o_flush_id_ex    = 1'b1;
                    w_flush_cnt_next = FlushLoad;
                    w_state_next     = (FlushLoad != 4'd0) ? StFlush : StRun;
                end else begin
                    o_pc_en = w_fetch_adv;
                end
                // Halt wins the next state; any same-cycle redirect above is still applied.
                if (i_halt_req) begin
                    w_state_next     = StHalt;
                    w_flush_cnt_next = 4'd0;
                end
            end

            StFlush: begin
                // Control flow seen here belongs to instructions being squashed: ignore it.
                o_imem_req    = 1'b1;
                o_pc_en       = w_fetch_adv;
                o_flush_if_id = 1'b1;
                o_flush_id_ex = 1'b1;
                if (r_flush_cnt <= 4'd1) begin
                    w_flush_cnt_next = 4'd0;
                    w_state_next     = StRun;
                end else begin
                    w_flush_cnt_next = r_flush_cnt - 4'd1;
                end
                if (i_halt_req) begin
                    w_state_next     = StHalt;
                    w_flush_cnt_next = 4'd0;
                end
            end

            StHalt: begin
                o_halted = 1'b1;
            end

            default: begin
                w_state_next     = StBoot;
                w_flush_cnt_next = 4'd0;
            end
        endcase
    end

`ifdef PC_SEQ_PERF_EN
    logic        w_active;
    logic        w_redirect_applied;
    logic        w_stall_cycle;
    logic [31:0] r_redirect_cnt;
    logic [31:0] r_stall_cnt;

    // Only RUN/FLUSH count, so both counters naturally freeze in HALT.
    assign w_active           = (r_state == StRun) || (r_state == StFlush);
    assign w_redirect_applied = (r_state == StRun) && w_redirect;
    assign w_stall_cycle      = w_active && !o_pc_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_redirect_cnt <= 32'd0;
            r_stall_cnt    <= 32'd0;
        end else begin
            if (w_redirect_applied) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
            if (w_stall_cycle) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign o_redirect_cnt = r_redirect_cnt;
    assign o_stall_cnt    = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer: directed scenarios followed by randomized traffic. A
// behavioural model pushes the expected outputs for every cycle into a queue; a monitor on the
// falling edge pops and compares them against the DUT.
module tb_pc_fetch_sequencer;

    localparam int unsigned FC = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       imem_ready = 1'b0;
    logic       stall = 1'b0;
    logic       ex_valid = 1'b0;
    logic       ex_branch = 1'b0;
    logic       ex_jal = 1'b0;
    logic       ex_jalr = 1'b0;
    logic       halt_req = 1'b0;
    logic [1:0] pc_sel;
    logic       pc_en;
    logic       imem_req;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       halted;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] redirect_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_sequencer #(
        .FLUSH_CYCLES(FC)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_imem_ready  (imem_ready),
        .i_stall       (stall),
        .i_ex_valid    (ex_valid),
        .i_ex_branch   (ex_branch),
        .i_ex_jal      (ex_jal),
        .i_ex_jalr     (ex_jalr),
        .i_halt_req    (halt_req),
`ifdef PC_SEQ_PERF_EN
        .o_redirect_cnt(redirect_cnt),
        .o_stall_cnt   (stall_cnt),
`endif
        .o_pc_sel      (pc_sel),
        .o_pc_en       (pc_en),
        .o_imem_req    (imem_req),
        .o_flush_if_id (flush_if_id),
        .o_flush_id_ex (flush_id_ex),
        .o_halted      (halted)
    );

    typedef struct packed {
        logic [1:0] sel;
        logic       en;
        logic       req;
        logic       fif;
        logic       fid;
        logic       hlt;
    } exp_t;

    exp_t exp_q[$];
`ifdef PC_SEQ_PERF_EN
    logic [31:0] exp_rcnt_q[$];
    logic [31:0] exp_scnt_q[$];
    logic [31:0] m_rcnt = 0;
    logic [31:0] m_scnt = 0;
`endif

    // Model: boot pending, halted, and number of flush cycles still owed after a redirect.
    bit m_boot = 1'b1;
    bit m_halted = 1'b0;
    int m_flush_left = 0;

    task automatic model_cycle();
        exp_t       e;
        bit         redir;
        logic [1:0] code;
        e     = '0;
        redir = ex_valid && (ex_jalr || ex_jal || ex_branch);
        code  = ex_jalr ? 2'b11 : (ex_jal ? 2'b10 : 2'b01);
        if (!rst_n) begin
            m_boot       = 1'b1;
            m_halted     = 1'b0;
            m_flush_left = 0;
`ifdef PC_SEQ_PERF_EN
            m_rcnt = 0;
            m_scnt = 0;
`endif
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_halted) begin
            e.hlt = 1'b1;
        end else if (m_flush_left > 0) begin
            e.req = 1'b1;
            e.fif = 1'b1;
            e.fid = 1'b1;
            e.en  = imem_ready && !stall;
            m_flush_left--;
            if (halt_req) begin
                m_halted     = 1'b1;
                m_flush_left = 0;
            end
        end else begin
            e.req = 1'b1;
            if (redir) begin
                e.sel        = code;
                e.en         = 1'b1;
                e.fif        = 1'b1;
                e.fid        = 1'b1;
                m_flush_left = int'(FC) - 1;
            end else begin
                e.en = imem_ready && !stall;
            end
            if (halt_req) begin
                m_halted     = 1'b1;
                m_flush_left = 0;
            end
        end
        exp_q.push_back(e);
`ifdef PC_SEQ_PERF_EN
        exp_rcnt_q.push_back(m_rcnt);
        exp_scnt_q.push_back(m_scnt);
        // Only an active (fetching) cycle counts; a redirect is the only case with sel != 00.
        if (e.req && e.sel != 2'b00) m_rcnt = m_rcnt + 1;
        if (e.req && !e.en) m_scnt = m_scnt + 1;
`endif
    endtask

    task automatic set_inputs(input bit r, input bit rdy, input bit stl, input bit v,
                              input bit br, input bit j, input bit jr, input bit h);
        rst_n      = r;
        imem_ready = rdy;
        stall      = stl;
        ex_valid   = v;
        ex_branch  = br;
        ex_jal     = j;
        ex_jalr    = jr;
        halt_req   = h;
    endtask

    task automatic drive(input bit r, input bit rdy, input bit stl, input bit v,
                         input bit br, input bit j, input bit jr, input bit h);
        @(posedge clk);
        #1;
        set_inputs(r, rdy, stl, v, br, j, jr, h);
        model_cycle();
    endtask

    exp_t mon_e;
    exp_t mon_got;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] mon_r;
    logic [31:0] mon_s;
`endif

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e   = exp_q.pop_front();
            mon_got = {pc_sel, pc_en, imem_req, flush_if_id, flush_id_ex, halted};
            checks++;
            if (mon_got !== mon_e) begin
                failures++;
                $display("FAIL outputs t=%0t got sel=%b en=%b req=%b fif=%b fid=%b hlt=%b need sel=%b en=%b req=%b fif=%b fid=%b hlt=%b",
                         $time, mon_got.sel, mon_got.en, mon_got.req, mon_got.fif, mon_got.fid,
                         mon_got.hlt, mon_e.sel, mon_e.en, mon_e.req, mon_e.fif, mon_e.fid,
                         mon_e.hlt);
            end
`ifdef PC_SEQ_PERF_EN
            mon_r = exp_rcnt_q.pop_front();
            mon_s = exp_scnt_q.pop_front();
            checks++;
            if (redirect_cnt !== mon_r) begin
                failures++;
                $display("FAIL redirect_cnt t=%0t got %0d need %0d", $time, redirect_cnt, mon_r);
            end
            checks++;
            if (stall_cnt !== mon_s) begin
                failures++;
                $display("FAIL stall_cnt t=%0t got %0d need %0d", $time, stall_cnt, mon_s);
            end
`endif
        end
    end

    int halt_cycles = 0;

    initial begin
        // Reset held for three cycles, then boot cycle, then first RUN cycle.
        repeat (3) drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);

        // JALR + branch together under stall: JALR select wins, flush window, back to RUN.
        drive(1, 1, 1, 1, 1, 0, 1, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);

        // JAL redirect, then a JAL arriving inside FLUSH must be ignored.
        drive(1, 1, 0, 1, 0, 1, 0, 0);
        drive(1, 1, 0, 1, 0, 1, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);

        // Memory not ready for four cycles.
        repeat (4) drive(1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);

        // Halt together with a taken branch: branch applied, then halted for good.
        drive(1, 1, 0, 1, 1, 0, 0, 1);
        repeat (20) drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 1,
                          $urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom_range(0, 1));
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);

        // Reset asserted mid-FLUSH: flushes must drop without a clock edge.
        drive(1, 1, 0, 1, 1, 0, 0, 0);
        @(posedge clk);
        #1;
        set_inputs(1, 1, 0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
            failures++;
            $display("FAIL flush_before_reset got fif=%b fid=%b need 1 1", flush_if_id, flush_id_ex);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_flush got fif=%b fid=%b need 0 0", flush_if_id, flush_id_ex);
        end
        model_cycle();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; a halted core is released with a reset after a while.
        for (int i = 0; i < 3000; i++) begin
            bit r;
            r = ($urandom_range(0, 199) != 0);
            if (m_halted) begin
                halt_cycles++;
                if (halt_cycles > 12) begin
                    r           = 1'b0;
                    halt_cycles = 0;
                end
            end
            drive(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending need 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
